// File: rtl/tick_delay_scheduler.sv
// Round-robin shared tick countdown: grants one requester, counts its delay in prescaled ticks, pulses Done.
// Latency: grant 1 cycle after request in IDLE; Done at G + max(Delay*TickDiv, 1); outputs registered.
// Backpressure: level requests are held until Done; dropping Req or Abort cancels the running job.
module tick_delay_scheduler #(
    parameter int TickDiv = 100000000,
    parameter int CntW    = 27,
    parameter int NumReq  = 4,
    parameter int DlyW    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NumReq-1:0]      i_req,
    input  logic [NumReq*DlyW-1:0] i_delay,
    input  logic                   i_abort,
    output logic [NumReq-1:0]      o_grant,
    output logic [NumReq-1:0]      o_done,
    output logic                   o_busy,
    output logic                   o_tick,
    output logic [DlyW-1:0]        o_remaining
);

    localparam int IdxW = $clog2(NumReq);
    localparam logic [CntW-1:0] TermCnt = CntW'(TickDiv - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
    localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NumReq);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [CntW-1:0]    r_presc;
    logic [IdxW-1:0]    r_rr;
    logic [IdxW-1:0]    r_gidx;
    logic [NumReq-1:0]  r_grant;
    logic [NumReq-1:0]  r_done;
    logic               r_busy;
    logic               r_tick;
    logic [DlyW-1:0]    r_rem;

    logic [IdxW:0]      w_idx;
    logic [IdxW-1:0]    w_pick;
    logic [DlyW-1:0]    w_pick_dly;
    logic [NumReq-1:0]  w_pick_oh;
    logic [IdxW-1:0]    w_rr_nxt;
    logic [CntW-1:0]    w_presc_inc;
    logic               w_wrap;

    // Scan downward so the last hit wins: that is the first set bit at or above the pointer.
    always_comb begin
        w_idx  = '0;
        w_pick = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr} + (IdxW + 1)'(k);
            if (w_idx >= NumReqW) begin
                w_idx = w_idx - NumReqW;
            end
            if (i_req[w_idx[IdxW-1:0]]) begin
                w_pick = w_idx[IdxW-1:0];
            end
        end
    end

    always_comb begin
        w_pick_dly  = i_delay[int'(w_pick)*DlyW +: DlyW];
        w_pick_oh   = {{(NumReq-1){1'b0}}, 1'b1} << w_pick;
        w_rr_nxt    = (r_gidx == LastIdx) ? '0 : r_gidx + 1'b1;
        w_presc_inc = r_presc + 1'b1;
        w_wrap      = (r_presc == TermCnt);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_rr    <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    r_tick  <= 1'b0;
                    r_done  <= '0;
                    if (|i_req) begin
                        r_state <= S_RUN;
                        r_gidx  <= w_pick;
                        r_grant <= w_pick_oh;
                        r_rem   <= w_pick_dly;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_abort || !i_req[r_gidx]) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_rem   <= '0;
                        r_presc <= '0;
                        r_tick  <= 1'b0;
                        r_rr    <= w_rr_nxt;
                    end else if (r_rem == '0 || (w_wrap && r_rem == DlyW'(1))) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                        r_rem   <= '0;
                        r_presc <= '0;
                        r_tick  <= 1'b0;
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        r_rem   <= r_rem - 1'b1;
                        r_tick  <= (TermCnt == '0);
                    end else begin
                        // Tick is registered, so raise it on the edge that lands on the terminal count.
                        r_presc <= w_presc_inc;
                        r_tick  <= (w_presc_inc == TermCnt);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_tick  <= 1'b0;
                    r_presc <= '0;
                    r_rr    <= w_rr_nxt;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_tick  <= 1'b0;
                    r_rem   <= '0;
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_tick      = r_tick;
    assign o_remaining = r_rem;

endmodule

// File: tb/tb_tick_delay_scheduler.sv
// Directed bench for tick_delay_scheduler with TickDiv=4, NumReq=4, DlyW=8.
module tb_tick_delay_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] dly;
    logic        abort;
    logic [3:0]  grant, done;
    logic        busy, tick;
    logic [7:0]  rem;

    int checks = 0;
    int errors = 0;

    tick_delay_scheduler #(
        .TickDiv (4),
        .CntW    (4),
        .NumReq  (4),
        .DlyW    (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_delay     (dly),
        .i_abort     (abort),
        .o_grant     (grant),
        .o_done      (done),
        .o_busy      (busy),
        .o_tick      (tick),
        .o_remaining (rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] dly;
        logic        abort;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic        tick;
        logic [7:0]  rem;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dl(input int d3, input int d2, input int d1, input int d0);
        return {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
    endfunction

    task automatic push(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic ab,
                        input logic [3:0] eg, input logic [3:0] ed, input logic eb,
                        input logic et, input int er);
        vec_t v;
        v.rst_n = r;  v.req = rq;   v.dly = d;   v.abort = ab;
        v.grant = eg; v.done = ed;  v.busy = eb; v.tick = et;  v.rem = er[7:0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                              input logic eb, input logic et, input int er);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".done"},  32'(done),  32'(ed));
        chk({tag, ".busy"},  32'(busy),  32'(eb));
        chk({tag, ".tick"},  32'(tick),  32'(et));
        chk({tag, ".rem"},   32'(rem),   32'(er));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'h0; abort = 1'b0; dly = '0;
        step(); step();
        expect_out("rst", 4'h0, 4'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    task automatic rr_seq();
        logic [3:0] oh;
        do_reset();
        req = 4'hF; dly = dl(1, 1, 1, 1);
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << (j % 4);
            step(); expect_out($sformatf("rr%0d.g", j), oh, 4'h0, 1'b1, 1'b0, 1);
            for (int s = 1; s <= 3; s++) begin
                step(); expect_out($sformatf("rr%0d.r%0d", j, s), oh, 4'h0, 1'b1, s == 3, 1);
            end
            step(); expect_out($sformatf("rr%0d.done", j), oh, oh, 1'b1, 1'b0, 0);
            step(); expect_out($sformatf("rr%0d.idle", j), 4'h0, 4'h0, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic cancel_seq(input bit use_abort);
        string t;
        t = use_abort ? "abort" : "withdraw";
        do_reset();
        req = 4'b0011; dly = dl(0, 0, 1, 5);
        step(); expect_out({t, ".g"}, 4'b0001, 4'h0, 1'b1, 1'b0, 5);
        for (int s = 1; s <= 6; s++) begin
            step(); expect_out($sformatf("%s.r%0d", t, s), 4'b0001, 4'h0, 1'b1, s == 3, (s < 4) ? 5 : 4);
        end
        if (use_abort) abort = 1'b1;
        else           req = 4'b0010;
        step(); expect_out({t, ".kill"}, 4'h0, 4'h0, 1'b0, 1'b0, 0);
        abort = 1'b0; req = 4'b0010;
        step(); expect_out({t, ".next"}, 4'b0010, 4'h0, 1'b1, 1'b0, 1);
    endtask

    task automatic midreset_seq();
        do_reset();
        req = 4'b0100; dly = dl(0, 2, 0, 0);
        step(); expect_out("mrst.g", 4'b0100, 4'h0, 1'b1, 1'b0, 2);
        for (int s = 1; s <= 5; s++) begin
            step(); expect_out($sformatf("mrst.r%0d", s), 4'b0100, 4'h0, 1'b1, s == 3, (s < 4) ? 2 : 1);
        end
        rst_n = 1'b0;
        step(); expect_out("mrst.kill", 4'h0, 4'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b1; req = 4'hF; dly = '0;
        step(); expect_out("mrst.restart", 4'b0001, 4'h0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0; req = 4'h0; dly = '0; abort = 1'b0;

        // Reset with all requests pending, then a zero-delay job for index 0.
        push(0, 4'hF, dl(0,0,0,0), 0, 4'h0, 4'h0, 0, 0, 0);
        push(0, 4'hF, dl(0,0,0,0), 0, 4'h0, 4'h0, 0, 0, 0);
        push(1, 4'hF, dl(0,0,0,0), 0, 4'b0001, 4'h0, 1, 0, 0);
        push(1, 4'hF, dl(0,0,0,0), 0, 4'b0001, 4'b0001, 1, 0, 0);
        push(1, 4'b0100, dl(0,3,0,0), 1, 4'h0, 4'h0, 0, 0, 0);
        // Single job Delay=3 on index 2; Abort in IDLE is ignored; Delay changes mid-job are ignored.
        push(1, 4'b0100, dl(0,3,0,0), 1, 4'b0100, 4'h0, 1, 0, 3);
        for (int t = 1; t <= 11; t++)
            push(1, 4'b0100, (t >= 2) ? dl(0,7,0,0) : dl(0,3,0,0), 0, 4'b0100, 4'h0, 1, (t % 4) == 3, 3 - t / 4);
        push(1, 4'b0100, dl(0,3,0,0), 0, 4'b0100, 4'b0100, 1, 0, 0);
        push(1, 4'b0000, dl(0,3,0,0), 1, 4'h0, 4'h0, 0, 0, 0);
        // Zero-delay job on index 1.
        push(1, 4'b0010, dl(0,0,0,0), 0, 4'b0010, 4'h0, 1, 0, 0);
        push(1, 4'b0010, dl(0,0,0,0), 0, 4'b0010, 4'b0010, 1, 0, 0);
        push(1, 4'b0000, dl(0,0,0,0), 0, 4'h0, 4'h0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            dly   = vecs[i].dly;
            abort = vecs[i].abort;
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].done,
                       vecs[i].busy, vecs[i].tick, vecs[i].rem);
        end

        rr_seq();
        cancel_seq(1'b1);
        cancel_seq(1'b0);
        midreset_seq();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
